i2c_eeprom_slave: RTL and testbench

Synthesizable I2C target that emulates a 24C02-style 256×8 EEPROM on the same two-wire bus the UART-to-EEPROM system drives as initiator. It sits on the far side of Scl/Sda, either in a loopback build that replaces the external EEPROM or as a bench responder. It supports byte and sequential writes, random, current-address and sequential reads, and repeated START. It does not stretch the clock.

---
 rtl/i2c_eeprom_slave.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_i2c_eeprom_slave.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_eeprom_slave.sv
// I2C target emulating a 24C02-style 256x8 EEPROM.
// Scl/Sda are synchronised and edge-detected. A two-process FSM decodes
// bus events into control strobes. The datapath holds the shift register,
// the address pointer, the memory and the open-drain Sda drive.
// The block never stretches the clock.
module i2c_eeprom_slave #(
    parameter logic [6:0] DEV_ADDR = 7'b1010000
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Scl,
    inout  wire  Sda,
    output logic Busy,
    output logic Wr_pulse
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_DEV_ADDR,
        S_ACK_DEV,
        S_WORD_ADDR,
        S_ACK_WA,
        S_WRITE_DATA,
        S_ACK_WD,
        S_READ_DATA,
        S_MACK
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Bus pin synchroniser (_p0/_p1) and edge-detect history (_p2)
    logic        scl_p0, scl_p1, scl_p2;
    logic        sda_p0, sda_p1, sda_p2;

    logic        scl_rise;
    logic        scl_fall;
    logic        start_det;
    logic        stop_det;

    logic [3:0]  bit_cnt;
    logic [7:0]  shreg;
    logic [7:0]  byte_in;
    logic [7:0]  ptr;
    logic [7:0]  mem [0:255];
    logic        sda_oe;

    // Control strobes from the FSM to the datapath
    logic        cnt_clr;
    logic        shift_in;
    logic        drive_bit;
    logic        load_rd;
    logic        ptr_load;
    logic        wr_en;
    logic        oe_set;
    logic        oe_clr;
    logic        busy_nxt;
    logic        byte_done;

    function automatic logic addr_match(input logic [7:0] b);
        return (b[7:1] == DEV_ADDR);
    endfunction

    // Open-drain pad: only ever pull low or release
    assign Sda = sda_oe ? 1'b0 : 1'bz;

    // Synchronise the asynchronous bus pins; idle bus level is high
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            scl_p0 <= 1'b1;
            scl_p1 <= 1'b1;
            scl_p2 <= 1'b1;
            sda_p0 <= 1'b1;
            sda_p1 <= 1'b1;
            sda_p2 <= 1'b1;
        end else begin
            // stage p0 -> p1: two-flop synchroniser
            scl_p0 <= Scl;
            sda_p0 <= Sda;
            scl_p1 <= scl_p0;
            sda_p1 <= sda_p0;
            // stage p1 -> p2: one-flop edge history
            scl_p2 <= scl_p1;
            sda_p2 <= sda_p1;
        end
    end

    assign scl_rise  =  scl_p1 & ~scl_p2;
    assign scl_fall  = ~scl_p1 &  scl_p2;
    // Sda edges only count as START/STOP while Scl is stably high
    assign start_det =  scl_p1 &  scl_p2 & ~sda_p1 &  sda_p2;
    assign stop_det  =  scl_p1 &  scl_p2 &  sda_p1 & ~sda_p2;

    assign byte_in   = {shreg[6:0], sda_p1};
    assign byte_done = (bit_cnt == 4'd7);

    // FSM state register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-event datapath strobes
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        shift_in  = 1'b0;
        drive_bit = 1'b0;
        load_rd   = 1'b0;
        ptr_load  = 1'b0;
        wr_en     = 1'b0;
        oe_set    = 1'b0;
        oe_clr    = 1'b0;
        busy_nxt  = Busy;

        if (start_det) begin
            state_nxt = S_DEV_ADDR;
            cnt_clr   = 1'b1;
            oe_clr    = 1'b1;
        end else if (stop_det) begin
            state_nxt = S_IDLE;
            cnt_clr   = 1'b1;
            oe_clr    = 1'b1;
            busy_nxt  = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt = S_IDLE;
                end

                S_DEV_ADDR: begin
                    if (scl_rise) begin
                        shift_in = 1'b1;
                        if (byte_done) begin
                            cnt_clr = 1'b1;
                            if (addr_match(byte_in)) begin
                                state_nxt = S_ACK_DEV;
                                busy_nxt  = 1'b1;
                            end else begin
                                state_nxt = S_IDLE;
                                busy_nxt  = 1'b0;
                            end
                        end
                    end
                end

                // ACK slots: pull low on the fall, leave on the 9th rise.
                // Sda stays driven until the next state's first fall.
                S_ACK_DEV: begin
                    if (scl_fall) begin
                        oe_set = 1'b1;
                    end else if (scl_rise) begin
                        // shreg[0] still holds the R/W bit of the address byte
                        if (shreg[0]) begin
                            state_nxt = S_READ_DATA;
                            load_rd   = 1'b1;
                        end else begin
                            state_nxt = S_WORD_ADDR;
                        end
                    end
                end

                S_WORD_ADDR: begin
                    if (scl_fall) begin
                        oe_clr = 1'b1;
                    end else if (scl_rise) begin
                        shift_in = 1'b1;
                        if (byte_done) begin
                            cnt_clr   = 1'b1;
                            ptr_load  = 1'b1;
                            state_nxt = S_ACK_WA;
                        end
                    end
                end

                S_ACK_WA, S_ACK_WD: begin
                    if (scl_fall) begin
                        oe_set = 1'b1;
                    end else if (scl_rise) begin
                        state_nxt = S_WRITE_DATA;
                    end
                end

                S_WRITE_DATA: begin
                    if (scl_fall) begin
                        oe_clr = 1'b1;
                    end else if (scl_rise) begin
                        shift_in = 1'b1;
                        if (byte_done) begin
                            cnt_clr   = 1'b1;
                            wr_en     = 1'b1;
                            state_nxt = S_ACK_WD;
                        end
                    end
                end

                // Eight falls drive bits MSB first; the ninth fall hands the
                // line back to the initiator for its ACK/NACK.
                S_READ_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            oe_clr    = 1'b1;
                            cnt_clr   = 1'b1;
                            state_nxt = S_MACK;
                        end else begin
                            drive_bit = 1'b1;
                        end
                    end
                end

                S_MACK: begin
                    if (scl_rise) begin
                        if (!sda_p1) begin
                            state_nxt = S_READ_DATA;
                            load_rd   = 1'b1;
                        end else begin
                            state_nxt = S_IDLE;
                            busy_nxt  = 1'b0;
                        end
                    end
                end

                default: begin
                    state_nxt = S_IDLE;
                    busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    // Control datapath: bit counter, pointer, Sda drive, status outputs
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            bit_cnt  <= 4'd0;
            ptr      <= 8'd0;
            sda_oe   <= 1'b0;
            Busy     <= 1'b0;
            Wr_pulse <= 1'b0;
        end else begin
            if (cnt_clr) begin
                bit_cnt <= 4'd0;
            end else if (shift_in || drive_bit) begin
                bit_cnt <= bit_cnt + 4'd1;
            end

            if (ptr_load) begin
                ptr <= byte_in;
            end else if (wr_en || load_rd) begin
                ptr <= ptr + 8'd1;
            end

            if (oe_clr) begin
                sda_oe <= 1'b0;
            end else if (oe_set) begin
                sda_oe <= 1'b1;
            end else if (drive_bit) begin
                sda_oe <= ~shreg[7];
            end

            Busy     <= busy_nxt;
            Wr_pulse <= wr_en;
        end
    end

    // Data storage: shift register and memory array, neither needs reset
    always_ff @(posedge Clk) begin
        if (shift_in) begin
            shreg <= byte_in;
        end else if (load_rd) begin
            shreg <= mem[ptr];
        end else if (drive_bit) begin
            shreg <= {shreg[6:0], 1'b0};
        end

        if (wr_en) begin
            mem[ptr] <= byte_in;
        end
    end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bench for i2c_eeprom_slave: a bit-banged I2C initiator drives directed
// and randomised transactions against a simple array model of the EEPROM.
module tb_i2c_eeprom_slave;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl = 1'b1;
    logic m_low = 1'b0;
    wire  sda;
    logic busy;
    logic wr_pulse;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_eeprom_slave #(.DEV_ADDR(7'b1010000)) dut (
        .Clk     (clk),
        .Rst     (rst),
        .Scl     (scl),
        .Sda     (sda),
        .Busy    (busy),
        .Wr_pulse(wr_pulse)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int wr_count = 0;
    int wr_double = 0;
    logic wr_prev = 1'b0;
    int exp_wr = 0;

    logic [7:0] ref_mem [256];
    int         ref_ptr = 0;
    logic [7:0] wbuf [8];

    always @(negedge clk) begin
        if (wr_pulse) wr_count <= wr_count + 1;
        if (wr_pulse && wr_prev) wr_double <= wr_double + 1;
        wr_prev <= wr_pulse;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        m_low = 1'b0; tick(5);
        scl = 1'b1;   tick(5);
        m_low = 1'b1; tick(5);
        scl = 1'b0;   tick(5);
    endtask

    task automatic bus_stop();
        m_low = 1'b1; tick(5);
        scl = 1'b1;   tick(5);
        m_low = 1'b0; tick(10);
    endtask

    task automatic send_bit(input logic b);
        tick(5);
        m_low = ~b;
        tick(5);
        scl = 1'b1; tick(10);
        scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_low = 1'b0;
        tick(10);
        scl = 1'b1; tick(5);
        ack = (sda === 1'b0);
        tick(5);
        scl = 1'b0;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b, output logic rel);
        m_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            tick(10);
            scl = 1'b1; tick(5);
            b[i] = (sda === 1'b1);
            tick(5);
            scl = 1'b0;
        end
        tick(5);
        m_low = ~nack;
        tick(5);
        scl = 1'b1; tick(5);
        rel = (sda === 1'b1);
        tick(5);
        scl = 1'b0;
        tick(2);
        m_low = 1'b0;
    endtask

    task automatic do_reads(input int n);
        logic [7:0] b;
        logic rel;
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, b, rel);
            check("rd_data", b, ref_mem[ref_ptr]);
            ref_ptr = (ref_ptr + 1) % 256;
            if (i == n - 1) check("mack_release", rel, 1);
        end
    endtask

    task automatic tx_write(input logic [7:0] addr, input int n);
        logic a;
        int w0;
        w0 = wr_count;
        bus_start();
        write_byte(8'hA0, a); check("wr_ack_dev", a, 1);
        write_byte(addr, a);  check("wr_ack_wa", a, 1);
        check("wr_busy", busy, 1);
        ref_ptr = addr;
        for (int i = 0; i < n; i++) begin
            write_byte(wbuf[i], a); check("wr_ack_data", a, 1);
            ref_mem[ref_ptr] = wbuf[i];
            ref_ptr = (ref_ptr + 1) % 256;
        end
        bus_stop();
        check("wr_busy_end", busy, 0);
        check("wr_pulses", wr_count - w0, n);
        exp_wr += n;
    endtask

    task automatic tx_read_random(input logic [7:0] addr, input int n);
        logic a;
        bus_start();
        write_byte(8'hA0, a); check("rr_ack_dev", a, 1);
        write_byte(addr, a);  check("rr_ack_wa", a, 1);
        bus_start();
        write_byte(8'hA1, a); check("rr_ack_rd", a, 1);
        ref_ptr = addr;
        do_reads(n);
        bus_stop();
        check("rr_busy_end", busy, 0);
    endtask

    task automatic tx_read_cur(input int n);
        logic a;
        bus_start();
        write_byte(8'hA1, a); check("cr_ack_rd", a, 1);
        check("cr_busy", busy, 1);
        do_reads(n);
        bus_stop();
        check("cr_busy_end", busy, 0);
    endtask

    initial begin
        logic a;
        int w0;
        int n;
        logic [7:0] addr;

        // Reset state
        tick(3);
        check("rst_sda", sda, 1);
        check("rst_busy", busy, 0);
        check("rst_wr_pulse", wr_pulse, 0);
        rst = 1'b0;
        tick(5);

        // Byte write then random read
        wbuf[0] = 8'h5A;
        tx_write(8'h10, 1);
        tx_read_random(8'h10, 1);

        // Seed 0x01 for the current-address read after the wrap test
        wbuf[0] = 8'($urandom);
        tx_write(8'h01, 1);

        // Sequential write and read across the 0xFF -> 0x00 wrap
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
        tx_write(8'hFE, 3);
        tx_read_random(8'hFE, 3);
        check("ptr_after_wrap", ref_ptr, 1);
        tx_read_cur(1);

        // Address mismatch
        w0 = wr_count;
        bus_start();
        write_byte(8'hA2, a);
        check("nomatch_ack", a, 0);
        check("nomatch_busy", busy, 0);
        bus_stop();
        check("nomatch_wr", wr_count - w0, 0);

        // STOP after four data bits discards the partial byte
        w0 = wr_count;
        bus_start();
        write_byte(8'hA0, a); check("ab_ack_dev", a, 1);
        write_byte(8'h10, a); check("ab_ack_wa", a, 1);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom));
        bus_stop();
        check("abort_wr", wr_count - w0, 0);
        tx_read_random(8'h10, 1);

        // Reset in the middle of a read of 0x00
        wbuf[0] = 8'h00;
        tx_write(8'h40, 1);
        bus_start();
        write_byte(8'hA0, a); check("rs_ack_dev", a, 1);
        write_byte(8'h40, a); check("rs_ack_wa", a, 1);
        bus_start();
        write_byte(8'hA1, a); check("rs_ack_rd", a, 1);
        m_low = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(10);
            scl = 1'b1; tick(5);
            check("rs_drive", sda, 0);
            tick(5);
            scl = 1'b0;
        end
        tick(10);
        scl = 1'b1; tick(5);
        rst = 1'b1;
        #1;
        check("rs_sda_rel", sda, 1);
        check("rs_busy", busy, 0);
        tick(3);
        rst = 1'b0;
        tick(5);
        ref_ptr = 0;
        tx_read_cur(1);

        // Randomised write/read-back bursts
        for (int k = 0; k < 6; k++) begin
            addr = 8'($urandom);
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            tx_write(addr, n);
            tx_read_random(addr, n);
        end

        tick(5);
        check("wr_total", wr_count, exp_wr);
        check("wr_width", wr_double, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
